// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: pointer adjust strobe, instruction-memory read port,
// decoder valid/ready handshake and branch redirect request.
interface instr_fetch_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] ip;
    logic [WORD_WIDTH-1:0] ip_adj;
    logic                  ip_update;
    logic [WORD_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_ack;
    logic [WORD_WIDTH-1:0] mem_data;
    logic [WORD_WIDTH-1:0] instr;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  redirect_valid;
    logic [WORD_WIDTH-1:0] redirect_adj;

    // Decoder handshake: instr transfers on a rising clk edge where instr_valid
    // and instr_ready are both high; instr/instr_valid hold until then.
    modport master (
        input  ip, mem_ack, mem_data, instr_ready, redirect_valid, redirect_adj,
        output ip_adj, ip_update, mem_addr, mem_rd, instr, instr_valid
    );

    modport slave (
        output ip, mem_ack, mem_data, instr_ready, redirect_valid, redirect_adj,
        input  ip_adj, ip_update, mem_addr, mem_rd, instr, instr_valid
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: reads memory at the pointer, presents the word to the
// decoder and steers the pointer (increment after fetch, relative redirect).
module instr_fetch #(
    parameter int          WORD_WIDTH = 16,
    parameter int unsigned INC        = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    instr_fetch_if.master bus,
    output logic [1:0]  fsm_state
);
    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] SETTLE = 2'd3;

    localparam logic [WORD_WIDTH-1:0] INC_W = WORD_WIDTH'(INC);

    logic [1:0]            state;
    logic                  pending;
    logic [WORD_WIDTH-1:0] pend_adj;

    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= SETTLE;
            pending         <= 1'b0;
            pend_adj        <= '0;
            bus.mem_rd      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.ip_update   <= 1'b0;
            bus.ip_adj      <= '0;
            bus.instr       <= '0;
            bus.instr_valid <= 1'b0;
        end else begin
            bus.ip_update <= 1'b0;
            case (state)
                // SETTLE waits for any in-flight pointer update to land before
                // sampling ip; a redirect that collides with a live strobe is
                // parked and issued on the next cycle.
                SETTLE: begin
                    if (bus.redirect_valid) begin
                        if (bus.ip_update) begin
                            pending  <= 1'b1;
                            pend_adj <= bus.redirect_adj;
                        end else begin
                            pending       <= 1'b0;
                            bus.ip_update <= 1'b1;
                            bus.ip_adj    <= bus.redirect_adj;
                        end
                    end else if (pending) begin
                        if (!bus.ip_update) begin
                            pending       <= 1'b0;
                            bus.ip_update <= 1'b1;
                            bus.ip_adj    <= pend_adj;
                        end
                    end else if (!bus.ip_update) begin
                        state        <= FETCH;
                        bus.mem_rd   <= 1'b1;
                        bus.mem_addr <= bus.ip;
                    end
                end
                FETCH: begin
                    if (bus.redirect_valid) begin
                        if (bus.mem_ack) begin
                            bus.mem_rd    <= 1'b0;
                            bus.ip_update <= 1'b1;
                            bus.ip_adj    <= bus.redirect_adj;
                            state         <= SETTLE;
                        end else begin
                            pending  <= 1'b1;
                            pend_adj <= bus.redirect_adj;
                            state    <= DRAIN;
                        end
                    end else if (bus.mem_ack) begin
                        bus.instr       <= bus.mem_data;
                        bus.instr_valid <= 1'b1;
                        bus.mem_rd      <= 1'b0;
                        bus.ip_update   <= 1'b1;
                        bus.ip_adj      <= INC_W;
                        state           <= HOLD;
                    end
                end
                DRAIN: begin
                    if (bus.mem_ack) begin
                        bus.mem_rd    <= 1'b0;
                        bus.ip_update <= 1'b1;
                        bus.ip_adj    <= bus.redirect_valid ? bus.redirect_adj : pend_adj;
                        pending       <= 1'b0;
                        state         <= SETTLE;
                    end else if (bus.redirect_valid) begin
                        pend_adj <= bus.redirect_adj;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        bus.instr_valid <= 1'b0;
                        state           <= SETTLE;
                        if (bus.ip_update) begin
                            pending  <= 1'b1;
                            pend_adj <= bus.redirect_adj;
                        end else begin
                            bus.ip_update <= 1'b1;
                            bus.ip_adj    <= bus.redirect_adj;
                        end
                    end else if (bus.instr_ready) begin
                        bus.instr_valid <= 1'b0;
                        state           <= SETTLE;
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end
endmodule
